// File: rtl/ghostbus_host_arb_pkg.sv
// Shared types and helpers for the ghostbus host arbiter.
package ghostbus_host_arb_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StStrb = 2'd1,
        StWait = 2'd2,
        StDone = 2'd3
    } state_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ghostbus_host_arb_rr_pick.sv
// Combinational round-robin picker: first set request strictly after i_last, wrapping.
module ghostbus_host_arb_rr_pick
    import ghostbus_host_arb_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_last,
    output logic            o_any,
    output logic [IW-1:0]   o_grant
);

    logic [IW-1:0]     w_start;
    logic [IW-1:0]     w_pos;
    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic [IW:0]       w_sum;

    assign w_start = (i_last >= IW'(NREQ - 1)) ? '0 : i_last + IW'(1);

    // Rotate so the highest-priority requester lands at bit 0.
    assign w_dbl = {i_req, i_req};
    assign w_rot = w_dbl[w_start +: NREQ];

    always_comb begin
        w_pos = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_pos = IW'(i);
            end
        end
    end

    assign w_sum   = {1'b0, w_pos} + {1'b0, w_start};
    assign o_grant = (w_sum >= (IW + 1)'(NREQ)) ? IW'(w_sum - (IW + 1)'(NREQ)) : IW'(w_sum);
    assign o_any   = |i_req;

endmodule

// File: rtl/ghostbus_host_arb.sv
// Round-robin arbiter sharing one ghostbus host port between NREQ requesters,
// one strobe per grant; all outputs registered.
module ghostbus_host_arb
    import ghostbus_host_arb_pkg::*;
#(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned AW     = 24,
    parameter int unsigned DW     = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NREQ-1:0]   i_req_valid,
    input  logic [NREQ-1:0]   i_req_we,
    input  logic [NREQ*AW-1:0] i_req_addr,
    input  logic [NREQ*DW-1:0] i_req_wdata,
    output logic [NREQ-1:0]   o_req_ready,
    output logic [NREQ-1:0]   o_rsp_valid,
    output logic [DW-1:0]     o_rsp_rdata,
    output logic [AW-1:0]     o_gb_addr,
    output logic [DW-1:0]     o_gb_dout,
    input  logic [DW-1:0]     i_gb_din,
    output logic              o_gb_we,
    output logic              o_gb_wstb,
    output logic              o_gb_rstb,
    output logic              o_busy
);

    localparam int unsigned IW = idx_width(NREQ);

    state_t            r_state;
    logic [IW-1:0]     r_last;
    logic              r_we;
    logic [CNT_W-1:0]  r_cnt;
    logic [NREQ-1:0]   r_req_ready;
    logic [NREQ-1:0]   r_rsp_valid;
    logic [DW-1:0]     r_rsp_rdata;
    logic [AW-1:0]     r_gb_addr;
    logic [DW-1:0]     r_gb_dout;
    logic              r_gb_we;
    logic              r_gb_wstb;
    logic              r_gb_rstb;
    logic              r_busy;

    state_t            w_state_nxt;
    logic [IW-1:0]     w_last_nxt;
    logic              w_we_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [NREQ-1:0]   w_ready_nxt;
    logic [NREQ-1:0]   w_rspv_nxt;
    logic [DW-1:0]     w_rdata_nxt;
    logic [AW-1:0]     w_addr_nxt;
    logic [DW-1:0]     w_dout_nxt;
    logic              w_gwe_nxt;
    logic              w_wstb_nxt;
    logic              w_rstb_nxt;
    logic              w_any;
    logic [IW-1:0]     w_pick;

    ghostbus_host_arb_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .i_req   (i_req_valid),
        .i_last  (r_last),
        .o_any   (w_any),
        .o_grant (w_pick)
    );

    // Outputs are computed one state ahead so the registered values line up
    // with the state they belong to (e.g. strobes are high during StStrb).
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_we_nxt    = r_we;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_gb_addr;
        w_dout_nxt  = r_gb_dout;
        w_rdata_nxt = r_rsp_rdata;
        w_ready_nxt = '0;
        w_rspv_nxt  = '0;
        w_gwe_nxt   = 1'b0;
        w_wstb_nxt  = 1'b0;
        w_rstb_nxt  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_any) begin
                    w_state_nxt = StStrb;
                    w_last_nxt  = w_pick;
                    w_we_nxt    = i_req_we[w_pick];
                    w_addr_nxt  = i_req_addr[w_pick*AW +: AW];
                    w_dout_nxt  = i_req_wdata[w_pick*DW +: DW];
                    w_ready_nxt = NREQ'(1) << w_pick;
                    w_gwe_nxt   = i_req_we[w_pick];
                    w_wstb_nxt  = i_req_we[w_pick];
                    w_rstb_nxt  = !i_req_we[w_pick];
                end
            end
            StStrb: begin
                if (r_we) begin
                    w_state_nxt = StDone;
                    w_rspv_nxt  = NREQ'(1) << r_last;
                end else begin
                    w_state_nxt = StWait;
                    w_cnt_nxt   = CNT_W'(RD_LAT - 1);
                end
            end
            StWait: begin
                if (r_cnt == '0) begin
                    w_rdata_nxt = i_gb_din;
                    w_state_nxt = StDone;
                    w_rspv_nxt  = NREQ'(1) << r_last;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_last      <= IW'(NREQ - 1);
            r_we        <= 1'b0;
            r_cnt       <= '0;
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_gb_addr   <= '0;
            r_gb_dout   <= '0;
            r_gb_we     <= 1'b0;
            r_gb_wstb   <= 1'b0;
            r_gb_rstb   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_last      <= w_last_nxt;
            r_we        <= w_we_nxt;
            r_cnt       <= w_cnt_nxt;
            r_req_ready <= w_ready_nxt;
            r_rsp_valid <= w_rspv_nxt;
            r_rsp_rdata <= w_rdata_nxt;
            r_gb_addr   <= w_addr_nxt;
            r_gb_dout   <= w_dout_nxt;
            r_gb_we     <= w_gwe_nxt;
            r_gb_wstb   <= w_wstb_nxt;
            r_gb_rstb   <= w_rstb_nxt;
            r_busy      <= (w_state_nxt != StIdle);
        end
    end

    assign o_req_ready = r_req_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_gb_addr   = r_gb_addr;
    assign o_gb_dout   = r_gb_dout;
    assign o_gb_we     = r_gb_we;
    assign o_gb_wstb   = r_gb_wstb;
    assign o_gb_rstb   = r_gb_rstb;
    assign o_busy      = r_busy;

endmodule
